// File: rtl/dsp_issue_writer.sv
// dsp_issue_writer: producer side of the DSP memory-buffer counter handshake.
// Latency: an accepted word is written (we/addr/data) one cycle after accept; its counter bumps on that same edge.
// Backpressure: img_ready/flt_ready drop while a 2^DEPTH_LOG2-entry ring half is full or its stream reached length.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, length                round start (IDLE only), words per stream
//   img_* / flt_*                image / filter word streams (valid/ready)
//   rama_* / ramb_*              image [0..511] / filter [512..1023] write ports
//   issue_a_alloc_counter        image words written
//   issue_a_dsp_counter          image words consumed by the DSP
//   filter_issue_counter         filter words written
//   filter_dsp_counter           filter words consumed by the DSP
//   filter_length                round length presented to the DSP controller
//   result, result_ready         DSP result and its valid level
//   round_result, done           captured result and its one-cycle update pulse
//   busy                         high while a round is in RUN or DRAIN
//   stall_cycles                 back-pressure statistic
//
// Optional feature: define DSP_ISSUE_WRITER_STALL_EN to build the stall_cycles
// counter; without it stall_cycles is tied to zero.

module dsp_issue_writer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PTR_W      = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PTR_W-1:0]      length,
  input  logic [17:0]           img_data,
  input  logic                  img_valid,
  output logic                  img_ready,
  input  logic [17:0]           flt_data,
  input  logic                  flt_valid,
  output logic                  flt_ready,
  output logic                  rama_we,
  output logic [DEPTH_LOG2:0]   rama_addr,
  output logic [17:0]           rama_data,
  output logic                  ramb_we,
  output logic [DEPTH_LOG2:0]   ramb_addr,
  output logic [17:0]           ramb_data,
  output logic [PTR_W-1:0]      issue_a_alloc_counter,
  input  logic [PTR_W-1:0]      issue_a_dsp_counter,
  output logic [PTR_W-1:0]      filter_issue_counter,
  input  logic [PTR_W-1:0]      filter_dsp_counter,
  output logic [PTR_W-1:0]      filter_length,
  input  logic [47:0]           result,
  input  logic                  result_ready,
  output logic [47:0]           round_result,
  output logic                  done,
  output logic                  busy,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(1) << DEPTH_LOG2;

  state_t                r_state;
  logic [PTR_W-1:0]      r_alloc_a;
  logic [PTR_W-1:0]      r_alloc_b;
  logic [PTR_W-1:0]      r_flen;
  logic                  r_rama_we;
  logic [DEPTH_LOG2:0]   r_rama_addr;
  logic [17:0]           r_rama_data;
  logic                  r_ramb_we;
  logic [DEPTH_LOG2:0]   r_ramb_addr;
  logic [17:0]           r_ramb_data;
  logic [47:0]           r_round_result;
  logic                  r_done;

  logic [PTR_W-1:0]      w_occ_a;
  logic [PTR_W-1:0]      w_occ_b;
  logic                  w_full_a;
  logic                  w_full_b;
  logic                  w_img_rdy;
  logic                  w_flt_rdy;
  logic                  w_img_acc;
  logic                  w_flt_acc;

  // Occupancy is a modulo-2^PTR_W difference of free-running counters, so a
  // DSP consume and a writer accept on the same edge both count correctly.
  assign w_occ_a  = r_alloc_a - issue_a_dsp_counter;
  assign w_occ_b  = r_alloc_b - filter_dsp_counter;
  assign w_full_a = (w_occ_a == FULL_OCC);
  assign w_full_b = (w_occ_b == FULL_OCC);

  // Ready depends only on registered state and counters, never on valid.
  assign w_img_rdy = (r_state == S_RUN) && (r_alloc_a != r_flen) && !w_full_a;
  assign w_flt_rdy = (r_state == S_RUN) && (r_alloc_b != r_flen) && !w_full_b;
  assign w_img_acc = w_img_rdy && img_valid;
  assign w_flt_acc = w_flt_rdy && flt_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_alloc_a      <= '0;
      r_alloc_b      <= '0;
      // All-ones keeps the controller's "length reached" detector quiet in IDLE.
      r_flen         <= '1;
      r_rama_we      <= 1'b0;
      r_rama_addr    <= '0;
      r_rama_data    <= '0;
      r_ramb_we      <= 1'b0;
      r_ramb_addr    <= '0;
      r_ramb_data    <= '0;
      r_round_result <= '0;
      r_done         <= 1'b0;
    end else begin
      r_rama_we <= w_img_acc;
      if (w_img_acc) begin
        r_rama_addr <= {1'b0, r_alloc_a[DEPTH_LOG2-1:0]};
        r_rama_data <= img_data;
        r_alloc_a   <= r_alloc_a + PTR_W'(1);
      end

      r_ramb_we <= w_flt_acc;
      if (w_flt_acc) begin
        r_ramb_addr <= {1'b1, r_alloc_b[DEPTH_LOG2-1:0]};
        r_ramb_data <= flt_data;
        r_alloc_b   <= r_alloc_b + PTR_W'(1);
      end

      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            r_flen  <= length;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if ((r_alloc_a == r_flen) && (r_alloc_b == r_flen)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (result_ready) begin
            r_round_result <= result;
            r_done         <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        // DSP-side counters only clear on rst, so DONE holds until then.
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DSP_ISSUE_WRITER_STALL_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if ((r_state == S_RUN) &&
                 ((img_valid && !w_img_rdy) || (flt_valid && !w_flt_rdy)) &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'h0000;
`endif

  assign img_ready             = w_img_rdy;
  assign flt_ready             = w_flt_rdy;
  assign rama_we               = r_rama_we;
  assign rama_addr             = r_rama_addr;
  assign rama_data             = r_rama_data;
  assign ramb_we               = r_ramb_we;
  assign ramb_addr             = r_ramb_addr;
  assign ramb_data             = r_ramb_data;
  assign issue_a_alloc_counter = r_alloc_a;
  assign filter_issue_counter  = r_alloc_b;
  assign filter_length         = r_flen;
  assign round_result          = r_round_result;
  assign done                  = r_done;
  assign busy                  = (r_state == S_RUN) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_dsp_issue_writer.sv
// Bench for dsp_issue_writer: round-level model checked every cycle, plus
// directed scenarios with literal expectations (basic round, full ring and
// wrap, simultaneous consume/accept, independent streams, guards, stall stats).
module tb_dsp_issue_writer;

`ifdef DSP_ISSUE_WRITER_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] length = '0;
  logic [17:0] img_data = 18'h01000;
  logic [17:0] flt_data = 18'h20000;
  logic        img_valid = 1'b0;
  logic        flt_valid = 1'b0;
  logic        img_ready, flt_ready;
  logic        rama_we, ramb_we;
  logic [9:0]  rama_addr, ramb_addr;
  logic [17:0] rama_data, ramb_data;
  logic [12:0] issue_a_alloc_counter, filter_issue_counter, filter_length;
  logic [12:0] issue_a_dsp_counter = '0;
  logic [12:0] filter_dsp_counter = '0;
  logic [47:0] result = '0;
  logic        result_ready = 1'b0;
  logic [47:0] round_result;
  logic        done, busy;
  logic [15:0] stall_cycles;

  dsp_issue_writer dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .flt_data(flt_data), .flt_valid(flt_valid), .flt_ready(flt_ready),
    .rama_we(rama_we), .rama_addr(rama_addr), .rama_data(rama_data),
    .ramb_we(ramb_we), .ramb_addr(ramb_addr), .ramb_data(ramb_data),
    .issue_a_alloc_counter(issue_a_alloc_counter),
    .issue_a_dsp_counter(issue_a_dsp_counter),
    .filter_issue_counter(filter_issue_counter),
    .filter_dsp_counter(filter_dsp_counter),
    .filter_length(filter_length),
    .result(result), .result_ready(result_ready),
    .round_result(round_result), .done(done), .busy(busy),
    .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- round-level model ----------------
  // m_state: 0 idle, 1 run, 2 drain, 3 done
  int     m_state = 0;
  int     m_len = 8191;
  int     m_a = 0, m_b = 0, m_stall = 0;
  bit     m_wa = 0, m_wb = 0, m_done = 0;
  int     m_addr_a = 0, m_addr_b = 0, m_data_a = 0, m_data_b = 0;
  longint m_res = 0;
  bit     ra, rb;

  function automatic bit m_rdy(input int cnt, input int dsp);
    return (m_state == 1) && (cnt != m_len) && (((cnt - dsp) & 8191) != 512);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_len = 8191; m_a = 0; m_b = 0; m_stall = 0;
      m_wa = 0; m_wb = 0; m_done = 0; m_res = 0;
      m_addr_a = 0; m_addr_b = 0; m_data_a = 0; m_data_b = 0;
    end else begin
      ra = m_rdy(m_a, int'(issue_a_dsp_counter));
      rb = m_rdy(m_b, int'(filter_dsp_counter));
      if (STALL_ON && m_state == 1 && ((img_valid && !ra) || (flt_valid && !rb)) && m_stall < 65535)
        m_stall++;
      m_done = 0;
      if (m_state == 0 && start && length != 0) begin
        m_state = 1; m_len = int'(length);
      end else if (m_state == 1 && m_a == m_len && m_b == m_len) begin
        m_state = 2;
      end else if (m_state == 2 && result_ready) begin
        m_state = 3; m_res = longint'(result); m_done = 1;
      end
      m_wa = ra && img_valid;
      if (m_wa) begin m_addr_a = m_a % 512; m_data_a = int'(img_data); m_a++; end
      m_wb = rb && flt_valid;
      if (m_wb) begin m_addr_b = 512 + (m_b % 512); m_data_b = int'(flt_data); m_b++; end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit     cmp_en = 0;
  int     qa[$];
  int     qb[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("img_ready", img_ready, m_rdy(m_a, int'(issue_a_dsp_counter)));
      chk("flt_ready", flt_ready, m_rdy(m_b, int'(filter_dsp_counter)));
      chk("rama_we", rama_we, m_wa);
      chk("rama_addr", rama_addr, m_addr_a);
      chk("rama_data", rama_data, m_data_a);
      chk("ramb_we", ramb_we, m_wb);
      chk("ramb_addr", ramb_addr, m_addr_b);
      chk("ramb_data", ramb_data, m_data_b);
      chk("alloc_a", issue_a_alloc_counter, m_a);
      chk("alloc_b", filter_issue_counter, m_b);
      chk("filter_length", filter_length, m_len);
      chk("busy", busy, (m_state == 1 || m_state == 2));
      chk("done", done, m_done);
      chk("round_result", round_result, m_res);
      chk("stall_cycles", stall_cycles, m_stall);
      if (rama_we) qa.push_back(int'(rama_addr));
      if (ramb_we) qb.push_back(int'(ramb_addr));
    end
  end

  // ---------------- stimulus ----------------
  bit follow = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    img_data = img_data + 18'd3;
    flt_data = flt_data + 18'd5;
    if (follow) begin
      issue_a_dsp_counter = 13'(m_a);
      filter_dsp_counter  = 13'(m_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1; tick(); tick();
    cmp_en = 1;
    chk("rst_filter_length", filter_length, 13'h1FFF);
    chk("rst_busy", busy, 0);
    chk("rst_alloc_a", issue_a_alloc_counter, 0);
    chk("rst_rama_we", rama_we, 0);
    chk("rst_round_result", round_result, 0);
    chk("rst_stall", stall_cycles, 0);
    rst = 1'b0;

    // basic round, length 4, DSP tracks the writer
    qa.delete(); qb.delete();
    follow = 1;
    length = 13'd4; start = 1'b1; tick(); start = 1'b0;
    chk("basic_busy", busy, 1);
    chk("basic_flen", filter_length, 4);
    img_valid = 1'b1; flt_valid = 1'b1;
    for (int n = 0; n < 20 && !(m_a == 4 && m_b == 4); n++) tick();
    img_valid = 1'b0; flt_valid = 1'b0;
    chk("basic_cnt_a", issue_a_alloc_counter, 4);
    chk("basic_cnt_b", filter_issue_counter, 4);
    tick(); tick();
    chk("basic_writes_a", qa.size(), 4);
    chk("basic_writes_b", qb.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr_a", (i < qa.size()) ? qa[i] : -1, i);
      chk("basic_addr_b", (i < qb.size()) ? qb[i] : -1, 512 + i);
    end
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    result = 48'h123; result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_result", round_result, 48'h123);
    tick();
    chk("done_low", done, 0);
    chk("done_busy", busy, 0);

    // full ring, DSP held at 0
    rst = 1'b1; tick(); rst = 1'b0;
    follow = 0; issue_a_dsp_counter = '0; filter_dsp_counter = '0;
    length = 13'd600; start = 1'b1; tick(); start = 1'b0;
    img_valid = 1'b1;
    for (int n = 0; n < 700 && m_a < 512; n++) tick();
    img_valid = 1'b0;
    chk("full_alloc", issue_a_alloc_counter, 512);
    chk("full_ready", img_ready, 0);
    tick();
    img_valid = 1'b1;
    repeat (10) tick();
    img_valid = 1'b0;
    chk("stall_10", stall_cycles, STALL_ON ? 10 : 0);
    chk("full_hold", issue_a_alloc_counter, 512);

    // DSP consume and valid arrive in the same cycle at occ=512
    qa.delete();
    issue_a_dsp_counter = 13'd1; img_valid = 1'b1;
    #1;
    chk("simul_ready", img_ready, 1);
    tick();
    chk("simul_alloc", issue_a_alloc_counter, 513);
    chk("simul_full_again", img_ready, 0);
    repeat (3) tick();
    img_valid = 1'b0;
    chk("no_overflow", issue_a_alloc_counter, 513);
    chk("wrap_writes", qa.size(), 1);
    chk("wrap_addr", (qa.size() > 0) ? qa[0] : -1, 0);

    // guards and independent streams
    rst = 1'b1; tick(); rst = 1'b0;
    follow = 1; issue_a_dsp_counter = '0; filter_dsp_counter = '0;
    length = 13'd0; start = 1'b1; tick(); start = 1'b0;
    chk("zero_len_busy", busy, 0);
    chk("zero_len_flen", filter_length, 13'h1FFF);
    length = 13'd5; start = 1'b1; tick(); start = 1'b0;
    chk("start5_busy", busy, 1);
    length = 13'd7; start = 1'b1; tick(); start = 1'b0;
    chk("start_in_run", filter_length, 5);
    img_valid = 1'b1; repeat (3) tick(); img_valid = 1'b0;
    chk("indep_a3", issue_a_alloc_counter, 3);
    chk("indep_b0", filter_issue_counter, 0);
    flt_valid = 1'b1; repeat (3) tick();
    chk("indep_a3b", issue_a_alloc_counter, 3);
    chk("indep_b3", filter_issue_counter, 3);
    chk("indep_still_run", img_ready, 1);
    chk("indep_we_b", ramb_we, 1);
    rst = 1'b1; tick(); rst = 1'b0; flt_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_we_b", ramb_we, 0);
    chk("midrst_alloc_a", issue_a_alloc_counter, 0);
    chk("midrst_alloc_b", filter_issue_counter, 0);
    chk("midrst_flen", filter_length, 13'h1FFF);
    tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_issue_writer.md
# dsp_issue_writer

Producer side of the DSP memory-buffer counter handshake. Accepts image and filter word streams with valid/ready and writes them into the two 512-entry ring halves of the memory buffer: image at [0-511] on port A, filter at [512-1023] on port B. It publishes issue counters that the DSP controller consumes, applies back-pressure when a ring is full, and captures the 48-bit DSP result when the controller reports it ready.

## Interface
Parameters:
- DEPTH_LOG2, 9, log2 of ring depth per half. The ring holds 2^DEPTH_LOG2 entries.
- PTR_W, 13, counter width. Must match the DSP controller counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- start  in  1  round start pulse; sampled only in IDLE
- length  in  13  words per stream for the round; latched on accepted start
- img_data  in  18  image word
- img_valid  in  1  image word valid
- img_ready  out  1  image word accepted this cycle when valid and ready are both high
- flt_data  in  18  filter word
- flt_valid  in  1  filter word valid
- flt_ready  out  1  filter word accepted this cycle when valid and ready are both high
- rama_we / rama_addr / rama_data  out  1/10/18  image write port
- ramb_we / ramb_addr / ramb_data  out  1/10/18  filter write port
- issue_a_alloc_counter  out  13  image words written
- issue_a_dsp_counter  in  13  image words consumed by the DSP
- filter_issue_counter  out  13  filter words written
- filter_dsp_counter  in  13  filter words consumed by the DSP
- filter_length  out  13  round length presented to the DSP controller
- result  in  48  raw DSP result
- result_ready  in  1  DSP result valid (level)
- round_result  out  48  captured result
- done  out  1  one-cycle pulse when round_result is updated
- busy  out  1  high in RUN and DRAIN
- stall_cycles  out  16  back-pressure statistic; see Configuration

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN: on start with length != 0. Latch length into filter_length. A start with length == 0 is ignored.
- RUN -> DRAIN: when both issue counters equal filter_length.
- DRAIN -> DONE: on result_ready. Latch result into round_result and pulse done.
- DONE is terminal until rst, because the DSP-side counters clear only on rst. start is ignored in every state except IDLE.
- Fill level per half: occ = alloc - dsp, computed modulo 2^13. The half is full when occ == 2^DEPTH_LOG2.
- img_ready = (state == RUN) && (issue_a_alloc_counter != filter_length) && !full_a. flt_ready follows the same rule using the filter counters.
- On an image accept, in the same edge:
  - rama_we = 1
  - rama_addr = {1'b0, cnt[8:0]}
  - rama_data = img_data
  - counter += 1
- On a filter accept, in the same edge:
  - ramb_we = 1
  - ramb_addr = {1'b1, cnt[8:0]}
  - ramb_data = flt_data
  - counter += 1
- The two streams are independent: either, both, or neither may be accepted in a cycle.
- Address wraps naturally on cnt[8:0]. Counters never wrap within a round, since length <= 8191.
- A DSP consume and a writer accept in the same cycle are both valid. Occupancy is re-evaluated from registered counters each cycle.

## Timing
- Write outputs (we, addr, data) are registered and assert in the cycle after the accept. The counter increments on that same edge, so the memory entry is written before the DSP controller can issue a read of it one cycle later.
- ready is combinational from registered state and counters only. It never depends on valid.
- done rises 1 cycle after result_ready is sampled in DRAIN.
- Reset values:
  - counters 0
  - filter_length 13'h1FFF. This keeps the DSP controller's ready detector from firing while IDLE.
  - we 0, addr 0, data 0
  - round_result 0
  - done 0, busy 0
  - stall_cycles 0
  - state IDLE
- rst mid-round returns to IDLE within 1 cycle and drops all write enables. Any in-flight data is discarded.

## Configuration
- DSP_ISSUE_WRITER_STALL_EN defined: stall_cycles increments, saturating at 16'hFFFF, on each cycle in RUN where either:
  - img_valid && !img_ready, or
  - flt_valid && !flt_ready.
- DSP_ISSUE_WRITER_STALL_EN undefined: stall_cycles is tied to 0 and no counter logic is built.

## Test plan
- Basic round: reset, start with length=4, drive 4 image and 4 filter words with valid held high, DSP counters follow 1 cycle behind. Expect:
  - rama_addr 0..3 and ramb_addr 512..515
  - both counters reach 4, state DRAIN
  - result_ready with result=48'h123 gives done pulse and round_result=48'h123
- Full ring: length=600, DSP counters held at 0. Expect img_ready low once issue_a_alloc_counter=512. Advance issue_a_dsp_counter to 1 and expect exactly one more accept, at rama_addr 0 (wrap).
- Simultaneous: at occ=512, the DSP consume and valid arrive in the same cycle. Expect the accept on the next cycle and no overflow write.
- Independent streams: image valid only for 3 cycles, then filter valid only. Expect counters 3/0, then 3/3, and no RUN -> DRAIN transition until both equal length.
- Guards:
  - start with length=0: stays IDLE, filter_length=13'h1FFF.
  - start during RUN: ignored.
  - rst during RUN: next cycle IDLE, we=0, counters 0.
- Stall stats with DSP_ISSUE_WRITER_STALL_EN: hold img_valid for 10 cycles while the ring is full. Expect stall_cycles=10. With the macro undefined, expect stall_cycles=0.
